// File: rtl/spi_cmd_parser_if.sv
// rtl/spi_cmd_parser_if.sv - byte stream in, register-file events out, for spi_cmd_parser
interface spi_cmd_parser_if;
  logic       frame_active;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] ctrl;
  logic [7:0] err_count;

  modport master (
    output frame_active, cmd, cmd_valid,
    input  rd_data, rd_valid, wr_strobe, wr_addr, ctrl, err_count
  );

  modport slave (
    input  frame_active, cmd, cmd_valid,
    output rd_data, rd_valid, wr_strobe, wr_addr, ctrl, err_count
  );
endinterface

// File: rtl/spi_cmd_parser.sv
// rtl/spi_cmd_parser.sv - SPI opcode parser driving a small register file
// Optional burst writes with address auto-increment: SPI_CMD_AUTOINC_EN
module spi_cmd_parser #(
  parameter int NREGS = 8
) (
  input logic             clk,
  input logic             rst,
  spi_cmd_parser_if.slave bus
);
  localparam int         AW        = (NREGS > 2) ? $clog2(NREGS) : 1;
  localparam logic [3:0] NREGS_L   = 4'(NREGS);
  localparam logic [2:0] LAST_ADDR = 3'(NREGS - 1);

  typedef enum logic [1:0] {IDLE, WDATA, SKIP} state_t;

  state_t     state_q;
  logic [7:0] regs_q [NREGS];
  logic [2:0] addr_q;
  logic [2:0] addr_d;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;
  logic       wr_strobe_q;
  logic [2:0] wr_addr_q;
  logic [7:0] err_count_q;
  logic       op_ok;

  // Reserved bits must be clear and the address must land inside the file.
  assign op_ok  = (bus.cmd[6:3] == 4'b0000) && ({1'b0, bus.cmd[2:0]} < NREGS_L);
  assign addr_d = (addr_q == LAST_ADDR) ? 3'd0 : addr_q + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 3'd0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 3'd0;
      err_count_q <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else begin
      rd_valid_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      if (!bus.frame_active) begin
        state_q <= IDLE;
      end else if (bus.cmd_valid) begin
        case (state_q)
          IDLE: begin
            if (!op_ok) begin
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'h01;
              state_q <= SKIP;
            end else if (bus.cmd[7]) begin
              addr_q  <= bus.cmd[2:0];
              state_q <= WDATA;
            end else begin
              rd_data_q  <= regs_q[bus.cmd[AW-1:0]];
              rd_valid_q <= 1'b1;
              state_q    <= SKIP;
            end
          end
          WDATA: begin
            regs_q[addr_q[AW-1:0]] <= bus.cmd;
            wr_strobe_q            <= 1'b1;
            wr_addr_q              <= addr_q;
`ifdef SPI_CMD_AUTOINC_EN
            addr_q  <= addr_d;
            state_q <= WDATA;
`else
            state_q <= SKIP;
`endif
          end
          default: state_q <= SKIP;
        endcase
      end
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.ctrl      = regs_q[0];
  assign bus.err_count = err_count_q;

`ifndef SPI_CMD_AUTOINC_EN
  logic unused_addr;
  assign unused_addr = ^addr_d;
`endif
endmodule

// File: doc/spi_cmd_parser.md
SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 Parameter NREGS, default 8, number of 8-bit registers in the register file (power of two, 2..8).
REQ-002 Port clk  input  1  system clock; all logic rising-edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port frame_active  input  1  high while the SPI select is asserted, already synchronized to clk.
REQ-005 Port cmd  input  8  received SPI byte.
REQ-006 Port cmd_valid  input  1  one-cycle strobe qualifying cmd.
REQ-007 Port rd_data  output  8  register contents returned for a read opcode.
REQ-008 Port rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-009 Port wr_strobe  output  1  one-cycle pulse when a register is written.
REQ-010 Port wr_addr  output  3  address of the register written by the current wr_strobe.
REQ-011 Port ctrl  output  8  continuous copy of register 0.
REQ-012 Port err_count  output  8  saturating count of malformed opcodes.

Function
REQ-013 Opcode byte format: bit7 = 1 write, 0 read; bits[6:3] must be 0000; bits[2:0] = address.
- An address >= NREGS is malformed.
REQ-014 The state machine SHALL have states IDLE (awaiting opcode), WDATA (awaiting write data) and SKIP (ignore bytes until the frame ends).
REQ-015 IDLE, valid write opcode: latch the address and go to WDATA.
REQ-016 IDLE, valid read opcode: drive rd_data = reg[addr] with rd_valid high in the cycle after cmd_valid, then go to SKIP.
REQ-017 IDLE, malformed opcode: increment err_count (saturating at 8'hFF, never wrapping) and go to SKIP.
REQ-018 WDATA, cmd_valid: write the byte to reg[addr] in the next cycle and pulse wr_strobe with wr_addr in that same cycle.
- The next state from WDATA is defined by REQ-026.
REQ-019 ctrl SHALL reflect a write to register 0 in the same cycle as its wr_strobe.
REQ-020 frame_active low SHALL force the state to IDLE in the next cycle regardless of state; a cmd_valid in such a cycle is discarded.
REQ-021 frame_active low mid-write (in WDATA) SHALL abort the write: no register change and no wr_strobe.
REQ-022 rd_valid and wr_strobe are never high in the same cycle.
REQ-023 Each output strobe is exactly one cycle wide.
REQ-024 Back-to-back cmd_valid on consecutive cycles SHALL be accepted without loss.

Reset
REQ-025 On rst high, immediately and asynchronously:
- state = IDLE;
- all registers = 8'h00, so ctrl = 8'h00;
- rd_data = 8'h00, rd_valid = 0, wr_strobe = 0, wr_addr = 0;
- err_count = 0.
After rst falls, the first cmd_valid seen while frame_active is high is treated as an opcode.

Configuration
REQ-026 Macro SPI_CMD_AUTOINC_EN.
- Defined: after each data byte the state stays in WDATA and the address increments modulo NREGS (wrapping from NREGS-1 to 0), giving burst writes within one frame.
- Undefined: after one data byte the state goes to SKIP, and further bytes in the frame are ignored.

Verification
REQ-027 Reset:
- Stimulus: assert rst while in WDATA.
- Required: state IDLE, ctrl = 00, err_count = 00 before the next clk edge.
REQ-028 Single write:
- Stimulus: frame with bytes 0x80, 0x5A.
- Required: wr_strobe once with wr_addr = 0; ctrl = 0x5A from the strobe cycle onward.
REQ-029 Read:
- Stimulus: write 0x83, 0xC3; new frame with byte 0x03.
- Required: rd_valid one cycle after cmd_valid with rd_data = 0xC3.
REQ-030 Malformed opcode:
- Stimulus: frame with bytes 0x48, 0x11.
- Required: err_count increments by 1; no wr_strobe; no rd_valid.
- Stimulus: 300 malformed frames.
- Required: err_count = 0xFF.
REQ-031 Abort and burst:
- Stimulus: frame 0x82 with frame_active dropped before any data byte.
- Required: reg 2 unchanged, no wr_strobe.
- Stimulus: frame 0x87, 0x01, 0x02, 0x03 with NREGS = 8.
- Required with SPI_CMD_AUTOINC_EN: regs 7, 0, 1 = 01, 02, 03.
- Required without it: only reg 7 = 01.
